dcpu_irqctrl: RTL
=================

# dcpu_irqctrl

Memory-mapped interrupt controller directly upstream of the dcpu core's `i_irq` input. It collects up to 16 asynchronous interrupt sources and latches rising edges into a pending register. It masks them and presents a single level to the core, deasserting it briefly after every register write so the core's rising-edge detector fires again while interrupts remain outstanding. It is a slave on the core's `o_addr/o_dat/i_dat/o_we/o_cs/i_ack` bus.

## Interface
- `NSRC`, 8, number of interrupt sources (1..16)
- `BASE`, 16'hFF00, bus base address; must be 8-word aligned (`BASE[2:0]==0`)
- `i_clk`  in  1  clock
- `i_reset`  in  1  reset; synchronous, active-high; clock `i_clk`
- `i_addr`  in  16  bus word address (core `o_addr`)
- `i_dat`  in  16  write data (core `o_dat`)
- `o_dat`  out  16  read data; 0 whenever `o_ack`=0, so it can be OR-muxed
- `i_we`  in  1  write strobe
- `i_cs`  in  1  bus chip select
- `o_ack`  out  1  access complete; one-cycle pulse, OR-combined into core `i_ack`
- `i_src`  in  NSRC  asynchronous interrupt sources
- `o_irq`  out  1  interrupt request to core `i_irq`

## Operation
- Select: `sel = i_cs && i_addr[15:3]==BASE[15:3]`. Offset is `i_addr[2:0]`.
- Register map, with NSRC-wide fields zero-extended on read:
  - 0 PENDING: read returns pending bits; write clears bits where `i_dat` is 1 (W1C).
  - 1 MASK: read/write; 1 enables the source.
  - 2 ID: read-only; index of the lowest-numbered bit of `PENDING & MASK`, or 16'hFFFF if none. Reading has no side effect.
  - 3 CTRL: bit0 = global enable (GEN); other bits read 0.
  - 4 LEVEL: see Configuration.
  - 5–7: read 0, writes ignored.
- Each source passes through a 2-FF synchronizer followed by an edge-detect FF. A synchronized 0→1 transition sets its PENDING bit.
- Set and W1C on the same bit in the same cycle: set wins, and the bit stays 1.
- `o_irq` is registered and behaves as follows:
  - Base value: `GEN && |(PENDING & MASK)`.
  - A 2-bit rearm counter loads 2 on every accepted write to any register. While the counter is nonzero, `o_irq` is driven 0 and the counter decrements.
  - This guarantees a low gap, so a still-pending interrupt produces a fresh rising edge after the ISR acknowledges one source.
- Reset: PENDING=0, MASK=0, GEN=0, LEVEL=0, synchronizer and edge FFs=0, rearm counter=0, `o_irq`=0, `o_ack`=0, `o_dat`=0.

## Timing
- Access handshake:
  - An access is accepted at edge e when `sel && !o_ack`.
  - Writes commit at edge e. `o_ack`=1 and `o_dat` are valid for the one cycle after e.
  - Read data reflects register state before any same-edge write.
- Back-to-back access: because acceptance requires `!o_ack`, a `i_cs` held high across the ack cycle is not re-accepted. The next access is accepted at edge e+2 at the earliest, a one-cycle bubble.
- Unselected `i_cs` (address outside the window) never produces `o_ack`.
- Source latency:
  - `i_src` sampled high at edge k.
  - Sync stage 2 high after k+1.
  - PENDING set at k+2.
  - `o_irq`=1 after k+3, provided GEN=1, the source is masked in, and the rearm counter is 0.
- Rearm: write accepted at edge w → `o_irq` forced 0 after w and after w+1 → `o_irq` re-evaluated at w+2.
- Reset mid-access: `o_ack` drops at the reset edge and the pending write is discarded.

## Configuration
- `DCPU_IRQCTRL_LEVEL_EN`:
  - Defined: offset 4 LEVEL is a read/write NSRC-wide register. For bit i=1, PENDING[i] follows the synchronized level (stage-2 output) each cycle; W1C has no lasting effect while the source is high. For bit i=0, the source is edge-triggered.
  - Undefined: LEVEL reads 0, writes are ignored, and all sources are edge-triggered. No level logic is synthesized.

## Test plan
- Reset, then read offsets 0..3 → data 0,0,16'hFFFF,0; each read gets `o_ack` exactly one cycle after acceptance; `o_irq`=0.
- Write MASK=16'h0005 and CTRL=1, then pulse `i_src[2]` for 3 cycles → `o_irq`=1 at edge k+3, ID reads 2, PENDING reads 16'h0004.
- `i_src[0]` and `i_src[2]` pending with MASK=5 → ID=0. Write PENDING=16'h0001 → `o_irq` low for 2 cycles, then high again; ID=2. Write PENDING=16'h0004 → `o_irq` stays 0.
- Hold `i_cs` with `sel` high for 4 cycles → acks on cycles 2 and 4 only. `i_addr`=BASE+8 with `i_cs`=1 → no ack.
- Edge on `i_src[1]` coinciding with W1C of bit 1 → PENDING[1] remains 1.
- With `DCPU_IRQCTRL_LEVEL_EN`: LEVEL=16'h0002, `i_src[1]` held high, W1C bit 1 → PENDING[1] reads 1. Deassert the source and wait 3 cycles → reads 0. Without the macro, LEVEL reads 0 after writing 16'hFFFF.

Source files
------------

// File: rtl/dcpu_irqctrl_if.sv
// Bus port of the dcpu interrupt controller: the core's word-addressed
// memory bus with chip select and a one-cycle ack.
interface dcpu_irqctrl_if;
  logic [15:0] addr;
  logic [15:0] wdat;
  logic [15:0] rdat;
  logic        we;
  logic        cs;
  logic        ack;

  modport master (output addr, wdat, we, cs, input rdat, ack);
  modport slave  (input addr, wdat, we, cs, output rdat, ack);
endinterface

// File: rtl/dcpu_irqctrl.sv
// Memory-mapped interrupt controller feeding the dcpu core's edge-sensitive irq input.
// Optional level-triggered sources: define DCPU_IRQCTRL_LEVEL_EN.
module dcpu_irqctrl #(
  parameter int          NSRC = 8,
  parameter logic [15:0] BASE = 16'hFF00
) (
  input  logic            i_clk,
  input  logic            i_reset,
  dcpu_irqctrl_if.slave   bus,
  input  logic [NSRC-1:0] i_src,
  output logic            o_irq
);
  logic [NSRC-1:0] s1, s2, s3, pend, mask, pend_nxt, w1c, rise, act;
  logic            gen, ack_q;
  logic [15:0]     rdat_q, rd, id;
  logic [1:0]      rearm, rearm_nxt;
  logic            sel, acc, wr;
  logic [2:0]      off;

  assign sel = bus.cs && (bus.addr[15:3] == BASE[15:3]);
  assign acc = sel && !ack_q;
  assign wr  = acc && bus.we;
  assign off = bus.addr[2:0];

  assign rise = s2 & ~s3;
  assign act  = pend & mask;
  assign w1c  = (wr && off == 3'd0) ? bus.wdat[NSRC-1:0] : '0;

`ifdef DCPU_IRQCTRL_LEVEL_EN
  logic [NSRC-1:0] level;
  // Level sources track the synchronized input, so W1C cannot stick while it is high.
  assign pend_nxt = (level & s2) | (~level & ((pend & ~w1c) | rise));
`else
  assign pend_nxt = (pend & ~w1c) | rise;
`endif

  // Descending scan so the lowest active index wins.
  always_comb begin
    id = 16'hFFFF;
    for (int i = NSRC - 1; i >= 0; i--)
      if (act[i]) id = 16'(i);
  end

  always_comb begin
    rd = '0;
    case (off)
      3'd0: rd[NSRC-1:0] = pend;
      3'd1: rd[NSRC-1:0] = mask;
      3'd2: rd = id;
      3'd3: rd[0] = gen;
`ifdef DCPU_IRQCTRL_LEVEL_EN
      3'd4: rd[NSRC-1:0] = level;
`endif
      default: rd = '0;
    endcase
  end

  // Looking at the next counter value makes o_irq low exactly for the two
  // cycles after the write edge.
  assign rearm_nxt = wr ? 2'd2 : (rearm != 2'd0 ? rearm - 2'd1 : 2'd0);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      s1     <= '0;
      s2     <= '0;
      s3     <= '0;
      pend   <= '0;
      mask   <= '0;
      gen    <= 1'b0;
      ack_q  <= 1'b0;
      rdat_q <= '0;
      rearm  <= '0;
      o_irq  <= 1'b0;
`ifdef DCPU_IRQCTRL_LEVEL_EN
      level  <= '0;
`endif
    end else begin
      s1     <= i_src;
      s2     <= s1;
      s3     <= s2;
      pend   <= pend_nxt;
      ack_q  <= acc;
      rdat_q <= acc ? rd : '0;
      rearm  <= rearm_nxt;
      o_irq  <= (rearm_nxt != 2'd0) ? 1'b0 : (gen && |act);
      if (wr) begin
        case (off)
          3'd1: mask <= bus.wdat[NSRC-1:0];
          3'd3: gen  <= bus.wdat[0];
`ifdef DCPU_IRQCTRL_LEVEL_EN
          3'd4: level <= bus.wdat[NSRC-1:0];
`endif
          default: ;
        endcase
      end
    end
  end

  assign bus.ack  = ack_q;
  assign bus.rdat = rdat_q;
endmodule
